// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between port A (CPU
// pipeline, default winner) and port B (UART loader / debug DMA).
// Grants are combinational; read data returns to the owning port one cycle
// after the grant.
// Build option MEM_ARB_FAIR_EN: adds a starvation counter that forces a
// grant to B after STARVE_LIMIT consecutive denied cycles. Without it,
// priority is strictly A-first.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [3:0]            a_wmask,
  input  logic [31:0]           a_wdata,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [3:0]            b_wmask,
  input  logic [31:0]           b_wdata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [31:0]           a_rdata,
  output logic [31:0]           b_rdata,
  output logic                  mem_wren,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must lie in 1..255");
  end

  // {a_rd, b_rd}: which port owns the read data arriving next cycle.
  logic [1:0] owner_q, owner_d;
  logic       force_b;

`ifdef MEM_ARB_FAIR_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign force_b = b_req & (wait_cnt_q == LIMIT);

  // Count consecutive cycles B is kept waiting, saturating at the limit.
  always_comb begin
    if (!b_req || b_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == LIMIT) begin
      wait_cnt_d = LIMIT;
    end else begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign force_b = 1'b0;
`endif

  // Grant selection; reset blocks both grants immediately, not at the next edge.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rstn) begin
      if (force_b) begin
        b_gnt = 1'b1;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req & ~a_req;
      end
    end
  end

  // RAM-side mux steered by the grant; with no grant the bus shows port A
  // but never writes.
  always_comb begin
    mem_addr  = a_addr;
    mem_wmask = a_wmask;
    mem_wdata = a_wdata;
    mem_wren  = a_gnt & a_we;
    if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wmask = b_wmask;
      mem_wdata = b_wdata;
      mem_wren  = b_we;
    end
  end

  // Remember which port was granted a read this cycle.
  always_comb begin
    owner_d = {a_gnt & ~a_we, b_gnt & ~b_we};
  end

  // Read ownership register; an in-flight read is dropped by reset.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state uses non-blocking assignments and an asynchronous clear so
    // every flop updates together and reset takes effect without a clock.
    if (!rstn) begin
      owner_q <= 2'b00;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign a_rvalid = owner_q[1];
  assign b_rvalid = owner_q[0];
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule
